// File: rtl/eth_gen_pkg.sv
// Shared constants, FSM state type and CRC-32 helpers for the GMII Ethernet/IPv4/UDP frame generator.
package eth_gen_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam int PRE_LEN     = 8;
  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;
  localparam int HDR_LEN     = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
  localparam int IFG_LEN     = 12;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_PAY,
    ST_FCS,
    ST_IFG
  } state_t;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // The CRC-32 final xor equals its init value; FCS bytes go out LSB first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = (crc ^ CRC_INIT) >> {idx, 3'b000};
    return fcs[7:0];
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide CRC-32 state register; only built when ETH_GEN_FCS_EN is defined.
`ifdef ETH_GEN_FCS_EN
module eth_crc32_d8
  import eth_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_step(crc, data);
    end
  end

endmodule
`endif

// File: rtl/eth_udp_gen.sv
// GMII Ethernet II / IPv4 / UDP frame generator with per-frame IP checksum and generated payload.
// Define ETH_GEN_FCS_EN to append a CRC-32 FCS; otherwise the frame ends after the payload.
module eth_udp_gen
  import eth_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0011_2233_4456,
  parameter logic [31:0] SRC_IP      = 32'hAC12_05DD,
  parameter logic [31:0] DST_IP      = 32'hAC12_05DF,
  parameter logic [15:0] SRC_PORT    = 16'h0521,
  parameter logic [15:0] DST_PORT    = 16'h0521,
  parameter logic [7:0]  TTL         = 8'h40,
  parameter int          PAYLOAD_LEN = 22,
  parameter int          PERIOD      = 12_500_000
) (
  input  logic        clk_125m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  gmii_tx,
  output logic        gmii_txv
);

  localparam logic [15:0] IP_TOT_LEN = 16'(IP_HDR_LEN + UDP_HDR_LEN + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN    = 16'(UDP_HDR_LEN + PAYLOAD_LEN);
  localparam logic [10:0] PAY_LAST   = 11'(PAYLOAD_LEN - 1);

  state_t                  state, state_nxt;
  logic [10:0]             cnt;
  logic [31:0]             per_cnt;
  logic [15:0]             ident, csum;
  logic                    tick, launch, last_byte, valid_nxt;
  logic [7:0]              byte_nxt;
  logic [HDR_LEN*8-1:0]    hdr, hdr_sh;

  function automatic logic [15:0] ip_csum(input logic [15:0] id);
    logic [31:0] s;
    s = {16'h0, IP_VER_IHL, 8'h00} + {16'h0, IP_TOT_LEN} + {16'h0, id}
      + {16'h0, TTL, IP_PROTO_UDP}
      + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
      + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!enable || per_cnt == 32'(PERIOD - 1)) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

  assign tick   = enable && (per_cnt == '0);
  assign launch = (state == ST_IDLE) && (start || tick);
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    last_byte = 1'b0;
    case (state)
      ST_IDLE: if (launch) state_nxt = ST_PRE;
      ST_PRE:  if (cnt == 11'(PRE_LEN - 1)) state_nxt = ST_HDR;
      ST_HDR:  if (cnt == 11'(HDR_LEN - 1)) state_nxt = ST_PAY;
      ST_PAY: begin
        if (cnt == PAY_LAST) begin
`ifdef ETH_GEN_FCS_EN
          state_nxt = ST_FCS;
`else
          state_nxt = ST_IFG;
          last_byte = 1'b1;
`endif
        end
      end
`ifdef ETH_GEN_FCS_EN
      ST_FCS: begin
        if (cnt == 11'd3) begin
          state_nxt = ST_IFG;
          last_byte = 1'b1;
        end
      end
`endif
      // One extra IFG cycle covers the output register, so busy drops 12 cycles after txv.
      ST_IFG:  if (cnt == 11'(IFG_LEN)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || state == ST_IDLE) ? 11'd0 : cnt + 11'd1;
      if (last_byte) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_125m) begin
    if (launch) begin
      ident <= frame_cnt;
      csum  <= ip_csum(frame_cnt);
    end
  end

  assign hdr = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                IP_VER_IHL, 8'h00, IP_TOT_LEN, ident, 16'h0000, TTL, IP_PROTO_UDP, csum,
                SRC_IP, DST_IP,
                SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

`ifdef ETH_GEN_FCS_EN
  logic [31:0] crc;
  logic        crc_en;

  assign crc_en = (state == ST_HDR) || (state == ST_PAY);

  eth_crc32_d8 u_crc (
    .clk   (clk_125m),
    .rst_n (rst_n),
    .clear (launch),
    .en    (crc_en),
    .data  (byte_nxt),
    .crc   (crc)
  );
`endif

  assign valid_nxt = (state == ST_PRE) || (state == ST_HDR) || (state == ST_PAY) || (state == ST_FCS);

  always_comb begin
    byte_nxt = 8'h00;
    hdr_sh   = hdr << {cnt, 3'b000};
    case (state)
      ST_PRE:  byte_nxt = (cnt == 11'(PRE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
      ST_HDR:  byte_nxt = hdr_sh[HDR_LEN*8-1 -: 8];
      ST_PAY:  byte_nxt = cnt[7:0] + ident[7:0];
`ifdef ETH_GEN_FCS_EN
      ST_FCS:  byte_nxt = fcs_byte(crc, cnt[1:0]);
`endif
      default: byte_nxt = 8'h00;
    endcase
  end

  // Output stage: one register between the byte mux and the GMII pins.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      gmii_tx  <= 8'h00;
      gmii_txv <= 1'b0;
    end else begin
      gmii_tx  <= byte_nxt;
      gmii_txv <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_eth_udp_gen.sv
// Scoreboard bench for eth_udp_gen: byte-exact frame model, timing, periodic launch, reset and length limits.
`timescale 1ns/1ps
module tb_eth_udp_gen;

  localparam int PLEN = 22;
`ifdef ETH_GEN_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif
  localparam int FLEN = 50 + PLEN + FCS_BYTES;
  localparam int SLEN = 50 + 18 + FCS_BYTES;
  localparam int LLEN = 50 + 1472 + FCS_BYTES;

  logic        clk = 1'b0, rst_n = 1'b0, rst_aux_n = 1'b0;
  logic        enable = 1'b0, start = 1'b0, s_start = 1'b0, l_start = 1'b0, off = 1'b0;
  logic        busy, s_busy, l_busy, gmii_txv, s_txv, l_txv;
  logic [15:0] frame_cnt, s_cnt, l_cnt;
  logic [7:0]  gmii_tx, s_tx, l_tx;

  always #4 clk = ~clk;

  eth_udp_gen #(.PERIOD(200)) dut (
    .clk_125m(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .busy(busy), .frame_cnt(frame_cnt), .gmii_tx(gmii_tx), .gmii_txv(gmii_txv));

  eth_udp_gen #(.PAYLOAD_LEN(18)) dut_s (
    .clk_125m(clk), .rst_n(rst_aux_n), .enable(off), .start(s_start),
    .busy(s_busy), .frame_cnt(s_cnt), .gmii_tx(s_tx), .gmii_txv(s_txv));

  eth_udp_gen #(.PAYLOAD_LEN(1472)) dut_l (
    .clk_125m(clk), .rst_n(rst_aux_n), .enable(off), .start(l_start),
    .busy(l_busy), .frame_cnt(l_cnt), .gmii_tx(l_tx), .gmii_txv(l_txv));

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];

  function automatic logic [15:0] model_csum(input logic [15:0] id, input int plen);
    logic [31:0] s;
    s = 32'h4500 + 32'(28 + plen) + {16'h0, id} + 32'h4011
      + 32'hAC12 + 32'h05DD + 32'hAC12 + 32'h05DF;
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic push_frame(input logic [15:0] id);
    logic [7:0]   f[$];
    logic [335:0] h;
    logic [31:0]  c;
    h = {48'hFFFF_FFFF_FFFF, 48'h0011_2233_4456, 16'h0800,
         16'h4500, 16'(28 + PLEN), id, 16'h0000, 16'h4011, model_csum(id, PLEN),
         32'hAC12_05DD, 32'hAC12_05DF,
         16'h0521, 16'h0521, 16'(8 + PLEN), 16'h0000};
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 0; i < 42; i++) f.push_back(h[335 - 8*i -: 8]);
    for (int i = 0; i < PLEN; i++) f.push_back(8'(i) + id[7:0]);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < f.size(); i++) begin
      c = c ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < FCS_BYTES; i++) f.push_back(c[8*i +: 8]);
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  // ---------------- monitors ----------------
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap [0:1599];
  logic [7:0] mon_exp;
  int         cur_len = 0, last_len = 0, frames = 0, idle_bad = 0;
  int         txv_fall_cyc = 0, busy_fall_cyc = 0;
  int         rise_cyc[$];
  logic       prev_txv = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (gmii_txv) begin
      if (!prev_txv) begin
        cur_len = 0;
        rise_cyc.push_back(cyc);
      end
      if (cur_len < 1600) cap[cur_len] = gmii_tx;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h at index %0d, expected no frame", gmii_tx, cur_len);
      end else begin
        mon_exp = exp_q.pop_front();
        check($sformatf("byte%0d", cur_len), gmii_tx, mon_exp);
      end
      cur_len++;
    end else begin
      if (gmii_tx !== 8'h00) idle_bad++;
      if (prev_txv) begin
        last_len = cur_len;
        frames++;
        txv_fall_cyc = cyc;
      end
    end
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_txv  = gmii_txv;
    prev_busy = busy;
  end

  int         s_len = 0, s_last = 0, l_len = 0, l_last = 0;
  logic       s_prev = 1'b0, l_prev = 1'b0;
  logic [7:0] l_b255 = 8'h00, l_b256 = 8'h00;

  always @(negedge clk) begin
    if (s_txv) begin
      if (!s_prev) s_len = 0;
      s_len++;
    end else if (s_prev) s_last = s_len;
    if (l_txv) begin
      if (!l_prev) l_len = 0;
      if (l_len == 50 + 255) l_b255 = l_tx;
      if (l_len == 50 + 256) l_b256 = l_tx;
      l_len++;
    end else if (l_prev) l_last = l_len;
    s_prev = s_txv;
    l_prev = l_txv;
  end

  // ---------------- helpers ----------------
  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (frames < n) begin
      errors++;
      $display("FAIL frame_timeout: got %0d frames, expected %0d", frames, n);
    end
  endtask

  task automatic launch_start();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_frame_fields(input string tag, input logic [15:0] id, input logic [15:0] cs,
                                    input logic [7:0] pay0, input logic [15:0] fcnt);
    check({tag, "_len"}, last_len, FLEN);
    check({tag, "_totlen"}, {cap[24], cap[25]}, 16'h0032);
    check({tag, "_ident"}, {cap[26], cap[27]}, id);
    check({tag, "_csum"}, {cap[32], cap[33]}, cs);
    check({tag, "_pay0"}, cap[50], pay0);
    check({tag, "_frame_cnt"}, frame_cnt, fcnt);
    check({tag, "_ifg"}, busy_fall_cyc - txv_fall_cyc, 12);
  endtask

  typedef struct {
    logic [15:0] id;
    logic [15:0] csum;
    logic [7:0]  pay0;
    logic [15:0] fcnt;
  } row_t;

  row_t rows[3];
  int   n0, nrise;

  initial begin
    rows[0] = '{16'h0000, 16'h16DB, 8'h00, 16'd1};
    rows[1] = '{16'h0001, 16'h16DA, 8'h01, 16'd2};
    rows[2] = '{16'h0002, 16'h16D9, 8'h02, 16'd3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_txv", gmii_txv, 1'b0);
    check("rst_tx", gmii_tx, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rst_aux_n = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b1;
    l_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    l_start = 1'b0;

    // back-to-back single frames
    for (int r = 0; r < 3; r++) begin
      n0 = frames;
      push_frame(rows[r].id);
      launch_start();
      check($sformatf("row%0d_busy_n1", r), busy, 1'b1);
      check($sformatf("row%0d_txv_n1", r), gmii_txv, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("row%0d_txv_n2", r), gmii_txv, 1'b1);
      wait_frames(n0 + 1, 400);
      repeat (16) @(posedge clk);
      check_frame_fields($sformatf("row%0d", r), rows[r].id, rows[r].csum, rows[r].pay0, rows[r].fcnt);
    end

    // periodic launch, ignored mid-frame start, start coinciding with a tick
    n0 = frames;
    nrise = rise_cyc.size();
    push_frame(16'd3);
    push_frame(16'd4);
    push_frame(16'd5);
    @(posedge clk);
    #1 enable = 1'b1;
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (369) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    enable = 1'b0;
    wait_frames(n0 + 3, 600);
    repeat (300) @(posedge clk);
    check("per_frames", frames - n0, 3);
    check("per_queue_left", exp_q.size(), 0);
    check("per_rises", rise_cyc.size() - nrise, 3);
    if (rise_cyc.size() >= nrise + 3) begin
      check("per_gap1", rise_cyc[nrise + 1] - rise_cyc[nrise], 200);
      check("per_gap2", rise_cyc[nrise + 2] - rise_cyc[nrise + 1], 200);
    end
    check("per_frame_cnt", frame_cnt, 16'd6);

    // asynchronous reset in the middle of a frame
    push_frame(16'd6);
    launch_start();
    begin
      int k;
      k = 0;
      while (!(gmii_txv && cur_len >= 30) && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("abort_reached_byte30", cur_len >= 30, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_txv", gmii_txv, 1'b0);
    check("abort_tx", gmii_tx, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_frame_cnt", frame_cnt, 16'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    n0 = frames;
    push_frame(16'd0);
    launch_start();
    wait_frames(n0 + 1, 400);
    repeat (16) @(posedge clk);
    check_frame_fields("post_rst", 16'h0000, 16'h16DB, 8'h00, 16'd1);

    // payload length limits
    begin
      int k;
      k = 0;
      while ((l_cnt != 16'd1 || l_txv) && k < 3000) begin
        @(posedge clk);
        k++;
      end
    end
    repeat (4) @(posedge clk);
    check("short_len", s_last, SLEN);
    check("short_frame_cnt", s_cnt, 16'd1);
    check("long_len", l_last, LLEN);
    check("long_frame_cnt", l_cnt, 16'd1);
    check("long_pay255", l_b255, 8'hFF);
    check("long_pay256", l_b256, 8'h00);
    check("idle_tx_zero", idle_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_udp_gen.md
# eth_udp_gen

Parametrised GMII frame generator for the 125 MHz Ethernet transmit path. It builds complete Ethernet II / IPv4 / UDP frames on the fly instead of replaying a fixed byte table:

- preamble and SFD
- headers from parameters
- IPv4 header checksum, computed per frame
- generated payload
- optional CRC-32 FCS

Frames are launched by a single-shot `start` pulse or periodically while `enable` is high. The output feeds the RGMII TX adapter directly.

## Interface
Parameters:
- `DST_MAC`, 48'hFFFF_FFFF_FFFF: destination MAC, sent MSB byte first.
- `SRC_MAC`, 48'h0011_2233_4456: source MAC.
- `SRC_IP`, 32'hAC12_05DD: IPv4 source address.
- `DST_IP`, 32'hAC12_05DF: IPv4 destination address.
- `SRC_PORT`, 16'h0521: UDP source port.
- `DST_PORT`, 16'h0521: UDP destination port.
- `TTL`, 8'h40: IPv4 TTL.
- `PAYLOAD_LEN`, 22: UDP payload bytes. Legal range 18..1472.
- `PERIOD`, 12_500_000: auto-launch interval in clock cycles. Must be at least 2.

Ports:
- `clk_125m`, in, 1: GMII TX clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: periodic auto-launch while high.
- `start`, in, 1: single-cycle request for one frame.
- `busy`, out, 1: high from launch through end of IFG.
- `frame_cnt`, out, 16: completed-frame count. Wraps 0xFFFF→0.
- `gmii_tx`, out, 8: TX byte, registered.
- `gmii_txv`, out, 1: TX valid, registered.

## Operation
- **Reset:** all outputs 0, FSM in IDLE, period counter 0, CRC register all-ones.
- **FSM states:** IDLE → PRE → HDR → PAY → FCS → IFG → IDLE.
  - PRE: 8 bytes, 0x55 ×7 then 0xD5.
  - HDR: 42 bytes, 14 Ethernet + 20 IPv4 + 8 UDP.
  - PAY: `PAYLOAD_LEN` bytes.
  - FCS: 4 bytes.
  - IFG: 12 cycles with `gmii_txv`=0.
- **Byte counter:** one 11-bit counter per state, cleared on every state transition.
- **Ethernet header:** `DST_MAC`, `SRC_MAC`, EtherType 0x0800.
- **IPv4 header, in order:**
  - 0x45, 0x00
  - total length = 28+`PAYLOAD_LEN`
  - identification = `frame_cnt` latched at launch
  - flags/fragment 0x0000
  - `TTL`, protocol 0x11
  - header checksum
  - `SRC_IP`, `DST_IP`
- **IPv4 header checksum:**
  - One's-complement sum of the ten header words, with the checksum word taken as 0.
  - Carry folded twice, then inverted.
  - Computed in IDLE from the latched identification and registered before HDR starts.
- **UDP header:** `SRC_PORT`, `DST_PORT`, length = 8+`PAYLOAD_LEN`, checksum 0x0000.
- **Payload:** byte i = (i[7:0] + identification[7:0]) mod 256.
- **Launch conditions:** only in IDLE.
  - `start`=1 launches a frame.
  - An auto tick launches a frame.
  - `start` and a tick in the same cycle launch one frame.
  - `start` while `busy` is ignored; it is not queued.
- **Period counter:**
  - Runs 0..`PERIOD`-1 while `enable`=1 and is held at 0 while `enable`=0.
  - A tick occurs when the counter equals 0 and `enable`=1.
  - A tick while `busy` is dropped.
- **`frame_cnt`:** increments in the cycle the last frame byte is driven, which is the last FCS byte (last PAY byte when FCS is compiled out).
- **Reset mid-frame:** `gmii_txv` and `gmii_tx` go to 0 immediately (asynchronously). The truncated frame is not counted.

## Timing
- Launch in cycle N: `busy`=1 at N+1, and the first 0x55 appears with `gmii_txv`=1 at N+2.
- `gmii_txv` stays high for exactly 54+`PAYLOAD_LEN` consecutive cycles, which is 76 at default.
- `busy` falls 12 cycles after `gmii_txv` falls.
- The earliest next launch is in the cycle `busy` is low.
- `gmii_tx` = 0 whenever `gmii_txv` = 0.

## Configuration
- `ETH_GEN_FCS_EN` defined:
  - CRC-32 runs over DST_MAC through the last payload byte.
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - FCS = ~crc, sent LSB byte first.
- `ETH_GEN_FCS_EN` undefined:
  - FCS state and CRC logic are removed; PAY goes directly to IFG.
  - Frame is 50+`PAYLOAD_LEN` bytes, so the frame must be completed downstream.

## Structure
- **Package `eth_gen_pkg`:**
  - Preamble byte, SFD byte, EtherType IPv4, UDP protocol number.
  - Header sizes 14/20/8, IFG length 12.
  - CRC polynomial and init value.
  - FSM state enum.
- **Sub-module `eth_crc32_d8`:** 8-bit-per-cycle CRC-32 update, with inputs clear, enable and data, and a 32-bit state output. It is instantiated only under `ETH_GEN_FCS_EN`.

## Test plan
- **Single frame, default parameters:** one `start` pulse →
  - 76 valid bytes.
  - Bytes 0..7 = 55×7, D5.
  - Bytes 8..21 = FF×6, 00 11 22 33 44 56, 08 00.
  - Total length 0x0032.
  - Checksum 0x16DB for identification 0.
- **Consecutive frames:** second `start` after `busy` falls →
  - identification 0x0001, checksum 0x16DA.
  - First payload byte 0x01.
  - `frame_cnt`=2.
- **FCS check:** frame passes a reference CRC-32 model. The 4 FCS bytes match the model.
- **Periodic mode:** `enable`=1 with `PERIOD`=200 →
  - frames start exactly 200 cycles apart.
  - `start` pulses mid-frame are ignored.
  - Simultaneous `start` and tick produce one frame.
- **Reset mid-frame:** `rst_n` low at byte 30 →
  - `gmii_txv`=0 immediately, `frame_cnt`=0.
  - After release, the next `start` gives a full frame with identification 0.
- **Length boundary, `ETH_GEN_FCS_EN` undefined:**
  - `PAYLOAD_LEN`=18 → 68 valid bytes.
  - `PAYLOAD_LEN`=1472 → 1522 valid bytes.
  - Payload byte 256 equals identification[7:0].
